astro_game_ctrl: RTL and testbench
==================================

// Module: astro_game_ctrl
// PURPOSE
//  Game sequencer for the Astro Barrier VGA game. It sits between the board inputs (Sw1, btnU) and the
//  target/bullet datapath. It generates the game-tick strobe that advances the datapath, arbitrates the
//  single bullet (fire grants against a per-level shot budget), tracks level/score, and drives the
//  QI/QGAME_1/QGAME_2/QDONE state shown on LD3/LD5/LD6/LD7 and the score shown on the SSDs.
// PARAMETERS
//  TICK_DIV        2097152  board_clk cycles per game_tick (>=2)
//  SHOTS_PER_LEVEL 8        shot budget loaded at each level start (1..15)
//  NUM_LEVELS      3        levels per game (1..4)
//  CLEAR_HOLD      64       game_ticks spent in QGAME_2 intermission (>=1)
// PORTS
//  board_clk     in   1  system clock
//  reset         in   1  asynchronous, active-high
//  start         in   1  game enable switch (async level; 2-flop synchronised internally)
//  fire_req      in   1  fire button (async level; synchronised, rising-edge detected)
//  bullet_active in   1  datapath: bullet in flight (synchronous to board_clk)
//  hit_pulse     in   1  datapath: target hit, 1 board_clk cycle
//  all_hit       in   1  datapath: every target in current level hit (level)
//  game_tick     out  1  1-cycle strobe every TICK_DIV cycles; datapath advances only on it
//  level_load    out  1  1-cycle pulse: datapath reloads target positions for `level`
//  fire_grant    out  1  1-cycle pulse: datapath launches bullet from ship position
//  state         out  2  00 QI, 01 QGAME_1 (play), 10 QGAME_2 (level clear), 11 QDONE
//  level         out  2  current level, 0-based
//  shots_left    out  4  remaining shots this level
//  score_bcd     out  8  two BCD digits, total hits this game
//  won           out  1  1 in QDONE if all levels were cleared, 0 if the game was lost
// BEHAVIOUR
//  Reset: all outputs 0, state QI, tick counter 0, inflight 0, synchronisers cleared.
//  Tick: counter 0..TICK_DIV-1, free-running in all states; game_tick=1 on cycle with count==TICK_DIV-1,
//   then wraps to 0. First tick is TICK_DIV cycles after reset release.
//  QI: on start_sync==1 -> QGAME_1 next cycle; on that transition: level=0, shots_left=SHOTS_PER_LEVEL,
//   score=00, won=0, inflight=0, level_load=1 for one cycle.
//  QGAME_1, priority high->low each cycle:
//   1. start_sync==0 -> QI (score/level held, shots_left held).
//   2. all_hit==1 -> QGAME_2, hold counter=0.
//   3. shots_left==0 && !inflight && !bullet_active -> QDONE, won=0.
//   Fire arbitration: fire edge && !bullet_active && !inflight && shots_left>0 -> fire_grant=1,
//    shots_left-=1 and inflight=1 in the same cycle. Edges failing the check are dropped (not queued).
//   inflight clears on the cycle bullet_active goes 1->0 (registered compare); the datapath raises
//    bullet_active within 2 game_ticks of a grant.
//   hit_pulse: score_bcd += 1 (BCD carry 09->10); saturates at 99. Accepted in QGAME_1 only.
//   hit_pulse and fire_grant in the same cycle both take effect.
//  QGAME_2: fire requests ignored; hold counter increments on each game_tick. start_sync==0 -> QI.
//   When hold reaches CLEAR_HOLD: if level==NUM_LEVELS-1 -> QDONE, won=1; else level+=1,
//   shots_left=SHOTS_PER_LEVEL, inflight=0, level_load=1 pulse, -> QGAME_1.
//  QDONE: all outputs held; fire ignored; start_sync==0 -> QI.
//  Reset mid-operation: immediate asynchronous return to reset values; pending pulses are lost.
//  game_tick, level_load and fire_grant are never high for two consecutive cycles.
// TESTING  (TICK_DIV=4, SHOTS_PER_LEVEL=3, NUM_LEVELS=2, CLEAR_HOLD=2)
//  1. Reset, hold 20 cycles -> game_tick high on cycles 4,8,12,16,20 only; state=00; outputs 0.
//  2. start=1 -> state 01 within 3 cycles, single level_load, shots_left=3, score=00; fire edge with
//     bullet_active=0 -> one fire_grant, shots_left=2; 2nd edge before bullet_active falls -> no grant.
//  3. 3 grants, each followed by bullet_active 1->0, all_hit=0 -> state 11, won=0, shots_left=0.
//  4. all_hit=1 at level 0 -> state 10; after 2 game_ticks level=1, shots_left=3, level_load,
//     state 01; all_hit=1 again -> after 2 ticks state 11, won=1.
//  5. 12 hit_pulses -> score_bcd=8'h12; preload to 99 and pulse again -> stays 8'h99;
//     same-cycle hit+grant -> both score and shots_left update.
//  6. Assert reset in QGAME_2 mid-hold -> state 00, all outputs 0 asynchronously; start=0 in QGAME_1 -> QI.

Source files
------------

// File: rtl/astro_game_ctrl.sv
// astro_game_ctrl
// Game sequencer for Astro Barrier. Generates the game-tick strobe, grants the single
// bullet against a per-level shot budget, tracks level and BCD score, and steps through
// idle / play / level-clear / done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// QI      | idle, waiting for the start switch
// QGAME_1 | play: fire arbitration and hit scoring active
// QGAME_2 | level clear intermission, counts CLEAR_HOLD game ticks
// QDONE   | game over, outputs frozen until start is dropped

module astro_game_ctrl #(
    parameter int TICK_DIV        = 2097152,
    parameter int SHOTS_PER_LEVEL = 8,
    parameter int NUM_LEVELS      = 3,
    parameter int CLEAR_HOLD      = 64
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fire_req,
    input  logic       bullet_active,
    input  logic       hit_pulse,
    input  logic       all_hit,
    output logic       game_tick,
    output logic       level_load,
    output logic       fire_grant,
    output logic [1:0] state,
    output logic [1:0] level,
    output logic [3:0] shots_left,
    output logic [7:0] score_bcd,
    output logic       won
);

    localparam logic [1:0] QI      = 2'b00;
    localparam logic [1:0] QGAME_1 = 2'b01;
    localparam logic [1:0] QGAME_2 = 2'b10;
    localparam logic [1:0] QDONE   = 2'b11;

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);

    localparam logic [CNT_W-1:0]  TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(CLEAR_HOLD - 1);
    localparam logic [3:0]        SHOTS_INIT = 4'(SHOTS_PER_LEVEL);
    localparam logic [1:0]        LAST_LEVEL = 2'(NUM_LEVELS - 1);

    // synchroniser and edge-detect flops
    logic start_s1_q, start_s2_q;
    logic fire_s1_q, fire_s2_q, fire_s3_q;
    logic bullet_prev_q;

    // tick generator
    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick_w;

    // sequencer state
    logic [1:0]        state_q,      state_d;
    logic [1:0]        level_q,      level_d;
    logic [3:0]        shots_q,      shots_d;
    logic [7:0]        score_q,      score_d;
    logic              won_q,        won_d;
    logic              inflight_q,   inflight_d;
    logic [HOLD_W-1:0] hold_q,       hold_d;
    logic              level_load_q, level_load_d;
    logic              fire_grant_q, fire_grant_d;

    // decoded conditions
    logic start_sync;
    logic fire_edge;
    logic bullet_fall;
    logic fire_ok;
    logic out_of_shots;

    // Increment a two-digit BCD value, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v != 8'h99) begin
            if (v[3:0] == 4'd9) begin
                r = {v[7:4] + 4'd1, 4'd0};
            end else begin
                r = {v[7:4], v[3:0] + 4'd1};
            end
        end
        return r;
    endfunction

    // Two-flop synchronisers for the switch and button, plus history flops for edge detect.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            start_s1_q    <= 1'b0;
            start_s2_q    <= 1'b0;
            fire_s1_q     <= 1'b0;
            fire_s2_q     <= 1'b0;
            fire_s3_q     <= 1'b0;
            bullet_prev_q <= 1'b0;
        end else begin
            start_s1_q    <= start;
            start_s2_q    <= start_s1_q;
            fire_s1_q     <= fire_req;
            fire_s2_q     <= fire_s1_q;
            fire_s3_q     <= fire_s2_q;
            bullet_prev_q <= bullet_active;
        end
    end

    assign start_sync   = start_s2_q;
    assign fire_edge    = fire_s2_q & ~fire_s3_q;
    assign bullet_fall  = bullet_prev_q & ~bullet_active;
    assign out_of_shots = (shots_q == 4'd0);
    assign fire_ok      = fire_edge & ~bullet_active & ~inflight_q & ~out_of_shots;

    // Free-running tick counter; the strobe is the terminal count itself, so it is low in reset.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick_w) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    assign tick_w = (tick_cnt_q == TICK_LAST);

    // Next-state and datapath-control decisions for the sequencer.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        shots_d      = shots_q;
        score_d      = score_q;
        won_d        = won_q;
        inflight_d   = inflight_q;
        hold_d       = hold_q;
        level_load_d = 1'b0;
        fire_grant_d = 1'b0;

        // a bullet that has landed frees the single bullet slot in any state
        if (bullet_fall) begin
            inflight_d = 1'b0;
        end

        case (state_q)
            QI: begin
                if (start_sync) begin
                    state_d      = QGAME_1;
                    level_d      = 2'd0;
                    shots_d      = SHOTS_INIT;
                    score_d      = 8'h00;
                    won_d        = 1'b0;
                    inflight_d   = 1'b0;
                    level_load_d = 1'b1;
                end
            end

            QGAME_1: begin
                if (hit_pulse) begin
                    score_d = bcd_inc(score_q);
                end
                if (!start_sync) begin
                    state_d = QI;
                end else if (all_hit) begin
                    state_d = QGAME_2;
                    hold_d  = '0;
                end else if (out_of_shots && !inflight_q && !bullet_active) begin
                    state_d = QDONE;
                    won_d   = 1'b0;
                end else if (fire_ok) begin
                    // grant, budget decrement and slot claim land together
                    fire_grant_d = 1'b1;
                    shots_d      = shots_q - 4'd1;
                    inflight_d   = 1'b1;
                end
            end

            QGAME_2: begin
                if (!start_sync) begin
                    state_d = QI;
                end else if (tick_w) begin
                    if (hold_q == HOLD_LAST) begin
                        if (level_q == LAST_LEVEL) begin
                            state_d = QDONE;
                            won_d   = 1'b1;
                        end else begin
                            state_d      = QGAME_1;
                            level_d      = level_q + 2'd1;
                            shots_d      = SHOTS_INIT;
                            inflight_d   = 1'b0;
                            level_load_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end

            default: begin
                if (!start_sync) begin
                    state_d = QI;
                end
            end
        endcase
    end

    // Sequencer registers; reset clears everything, including any pending pulse.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q      <= QI;
            level_q      <= 2'd0;
            shots_q      <= 4'd0;
            score_q      <= 8'h00;
            won_q        <= 1'b0;
            inflight_q   <= 1'b0;
            hold_q       <= '0;
            level_load_q <= 1'b0;
            fire_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            shots_q      <= shots_d;
            score_q      <= score_d;
            won_q        <= won_d;
            inflight_q   <= inflight_d;
            hold_q       <= hold_d;
            level_load_q <= level_load_d;
            fire_grant_q <= fire_grant_d;
        end
    end

    assign game_tick  = tick_w;
    assign level_load = level_load_q;
    assign fire_grant = fire_grant_q;
    assign state      = state_q;
    assign level      = level_q;
    assign shots_left = shots_q;
    assign score_bcd  = score_q;
    assign won        = won_q;

endmodule

// File: tb/tb_astro_game_ctrl.sv
// Testbench for astro_game_ctrl with small parameters. Expected values come from a
// game-level model (hit count, shot budget, bullet slot, level number) kept in the bench.

module tb_astro_game_ctrl;

    localparam int TD  = 4;
    localparam int SPL = 3;
    localparam int NL  = 2;
    localparam int CH  = 2;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_CLR  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       fire_req = 1'b0;
    logic       bullet_active = 1'b0;
    logic       hit_pulse = 1'b0;
    logic       all_hit = 1'b0;
    logic       game_tick, level_load, fire_grant, won;
    logic [1:0] state, level;
    logic [3:0] shots_left;
    logic [7:0] score_bcd;

    int checks = 0;
    int errors = 0;

    // pulse counters, sampled 1 ns after each falling edge
    int tick_cnt  = 0;
    int load_cnt  = 0;
    int grant_cnt = 0;
    logic [2:0] prev_pulse = 3'b000;

    // game-level reference model
    int  shots_m;
    int  score_m;
    int  level_m;
    bit  inflight_m;
    bit  play_m;

    astro_game_ctrl #(
        .TICK_DIV       (TD),
        .SHOTS_PER_LEVEL(SPL),
        .NUM_LEVELS     (NL),
        .CLEAR_HOLD     (CH)
    ) dut (
        .board_clk    (clk),
        .reset        (reset),
        .start        (start),
        .fire_req     (fire_req),
        .bullet_active(bullet_active),
        .hit_pulse    (hit_pulse),
        .all_hit      (all_hit),
        .game_tick    (game_tick),
        .level_load   (level_load),
        .fire_grant   (fire_grant),
        .state        (state),
        .level        (level),
        .shots_left   (shots_left),
        .score_bcd    (score_bcd),
        .won          (won)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        return 8'(((s / 10) * 16) + (s % 10));
    endfunction

    always @(negedge clk) begin
        #1;
        if (reset) begin
            prev_pulse = 3'b000;
        end else begin
            if ({game_tick, level_load, fire_grant} != 3'b000)
                check("pulse_single_cycle", 32'({game_tick, level_load, fire_grant} & prev_pulse), 32'd0);
            if (game_tick)  tick_cnt++;
            if (level_load) load_cnt++;
            if (fire_grant) grant_cnt++;
            prev_pulse = {game_tick, level_load, fire_grant};
        end
    end

    task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(exp));
    endtask

    task automatic new_game_model();
        shots_m    = SPL;
        score_m    = 0;
        level_m    = 0;
        inflight_m = 1'b0;
        play_m     = 1'b1;
    endtask

    task automatic do_fire(input string tag);
        int g0;
        bit exp_g;
        exp_g = play_m && !bullet_active && !inflight_m && (shots_m > 0);
        g0 = grant_cnt;
        fire_req = 1'b1;
        repeat (6) @(negedge clk);
        fire_req = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_g) begin
            shots_m--;
            inflight_m = 1'b1;
        end
        check(tag, 32'(grant_cnt - g0), 32'(exp_g));
        check({tag, "_shots"}, 32'(shots_left), 32'(shots_m));
    endtask

    task automatic bullet_flight();
        bullet_active = 1'b1;
        repeat (2) @(negedge clk);
        if ($urandom_range(0, 1) == 1) do_fire("fire_while_bullet");
        bullet_active = 1'b0;
        inflight_m = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit_pulse = 1'b1;
            @(negedge clk);
            hit_pulse = 1'b0;
            if (play_m) score_m++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, l0, n_rand;

        // 1: reset, then tick cadence and idle outputs
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({game_tick, level_load, fire_grant, state, level, shots_left, score_bcd, won}), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("tick_cycle_%0d", i), 32'(game_tick), 32'((i % TD) == 0));
            if (i == 1 || i == 20) begin
                check("idle_state", 32'(state), 32'(S_IDLE));
                check("idle_outputs", 32'({level_load, fire_grant, level, shots_left, score_bcd, won}), 32'd0);
            end
            @(negedge clk);
        end

        // 2: start a game, one grant, a dropped second edge
        l0 = load_cnt;
        start = 1'b1;
        new_game_model();
        wait_state(S_PLAY, 3, "start_to_play");
        @(negedge clk);
        check("start_level_load", 32'(load_cnt - l0), 32'd1);
        check("start_shots", 32'(shots_left), 32'(SPL));
        check("start_score", 32'(score_bcd), 32'(to_bcd(0)));
        check("start_level", 32'(level), 32'd0);
        do_fire("fire_first");
        do_fire("fire_inflight_dropped");
        bullet_flight();

        // 3: spend the whole budget without clearing the level
        do_fire("fire_second");
        bullet_flight();
        do_fire("fire_third");
        bullet_flight();
        wait_state(S_DONE, 4, "lost_done");
        play_m = 1'b0;
        check("lost_won", 32'(won), 32'd0);
        check("lost_shots", 32'(shots_left), 32'd0);
        do_fire("fire_in_done");
        start = 1'b0;
        wait_state(S_IDLE, 4, "done_to_idle");

        // 5: scoring, BCD carry, same-cycle hit and grant, saturation
        l0 = load_cnt;
        start = 1'b1;
        new_game_model();
        wait_state(S_PLAY, 3, "restart_play");
        @(negedge clk);
        check("restart_level_load", 32'(load_cnt - l0), 32'd1);
        check("restart_score", 32'(score_bcd), 32'(to_bcd(0)));
        hits(12);
        check("score_12", 32'(score_bcd), 32'(to_bcd(score_m)));
        t0 = grant_cnt;
        fire_req = 1'b1;
        repeat (2) @(negedge clk);
        hit_pulse = 1'b1;
        @(negedge clk);
        hit_pulse = 1'b0;
        fire_req = 1'b0;
        repeat (4) @(negedge clk);
        score_m++;
        shots_m--;
        inflight_m = 1'b1;
        check("hit_grant_grant", 32'(grant_cnt - t0), 32'd1);
        check("hit_grant_score", 32'(score_bcd), 32'(to_bcd(score_m)));
        check("hit_grant_shots", 32'(shots_left), 32'(shots_m));
        bullet_flight();
        n_rand = int'($urandom_range(1, 30));
        hits(n_rand);
        check("score_random", 32'(score_bcd), 32'(to_bcd(score_m)));
        hits(99 - score_m + 2);
        check("score_saturate", 32'(score_bcd), 32'h99);

        // 4: level clear intermission, next level, final clear
        all_hit = 1'b1;
        wait_state(S_CLR, 3, "clear_level0");
        all_hit = 1'b0;
        play_m = 1'b0;
        t0 = tick_cnt;
        l0 = load_cnt;
        wait_state(S_PLAY, CH * TD + 4, "clear_to_play");
        check("clear_ticks", 32'(tick_cnt - t0), 32'(CH));
        @(negedge clk);
        level_m++;
        shots_m = SPL;
        inflight_m = 1'b0;
        play_m = 1'b1;
        check("next_level_load", 32'(load_cnt - l0), 32'd1);
        check("next_level", 32'(level), 32'(level_m));
        check("next_shots", 32'(shots_left), 32'(shots_m));
        check("next_score_kept", 32'(score_bcd), 32'(to_bcd(score_m)));
        do_fire("fire_level1");
        bullet_flight();
        all_hit = 1'b1;
        wait_state(S_CLR, 3, "clear_level1");
        all_hit = 1'b0;
        play_m = 1'b0;
        t0 = tick_cnt;
        wait_state(S_DONE, CH * TD + 4, "won_done");
        check("won_ticks", 32'(tick_cnt - t0), 32'(CH));
        check("won_flag", 32'(won), 32'd1);
        check("won_level", 32'(level), 32'(NL - 1));
        check("won_shots_held", 32'(shots_left), 32'(shots_m));
        start = 1'b0;
        wait_state(S_IDLE, 4, "won_to_idle");
        check("idle_score_held", 32'(score_bcd), 32'(to_bcd(score_m)));

        // 6: asynchronous reset in the intermission, then start dropped in play
        start = 1'b1;
        new_game_model();
        wait_state(S_PLAY, 3, "game3_play");
        hits(3);
        all_hit = 1'b1;
        wait_state(S_CLR, 3, "game3_clear");
        all_hit = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'(S_IDLE));
        check("async_reset_outputs", 32'({game_tick, level_load, fire_grant, state, level, shots_left, score_bcd, won}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        new_game_model();
        wait_state(S_PLAY, 4, "after_reset_play");
        hits(2);
        start = 1'b0;
        wait_state(S_IDLE, 4, "stop_to_idle");
        check("stop_score_held", 32'(score_bcd), 32'(to_bcd(score_m)));
        check("stop_shots_held", 32'(shots_left), 32'(shots_m));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
